// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, counter width.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int iter_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int ITER_W = iter_w(DEF_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// One multiply (shift-add) or divide (restore-subtract) iteration; purely combinational.
// Latency 0; no flow control, the caller owns sequencing.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_mode,     // 0 multiply, 1 divide
  input  logic [WIDTH-1:0] i_acc,      // product upper half / partial remainder
  input  logic [WIDTH-1:0] i_operand,  // multiplicand / divisor
  input  logic             i_bit,      // mul: multiplier lsb; div: next dividend bit
  output logic [WIDTH-1:0] o_acc,
  output logic             o_bit       // mul: bit entering the low half; div: quotient bit
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_sum   = {1'b0, i_acc} + (i_bit ? {1'b0, i_operand} : '0);
  assign w_shift = {i_acc, i_bit};
  assign w_ge    = (w_shift >= {1'b0, i_operand});
  // Only taken when w_shift >= operand, so the true difference fits WIDTH bits.
  assign w_diff  = w_shift[WIDTH-1:0] - i_operand;

  always_comb begin
    o_acc = '0;
    o_bit = 1'b0;
    if (i_mode) begin
      if (w_ge) begin
        o_acc = w_diff;
        o_bit = 1'b1;
      end else begin
        o_acc = w_shift[WIDTH-1:0];
        o_bit = 1'b0;
      end
    end else begin
      o_acc = w_sum[WIDTH:1];
      o_bit = w_sum[0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers; result 33 edges after start, busy stalls issue.
// Signed ops and their sign fix-up exist only when MULDIV_SIGNED_EN is defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = iter_w(WIDTH);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div;

  logic             w_last;
  logic             w_div_op;
  logic [WIDTH-1:0] w_rs_mag;
  logic [WIDTH-1:0] w_rt_mag;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic [WIDTH-1:0] w_step_acc;
  logic             w_step_bit;

  assign w_last   = (r_cnt == CNT_W'(WIDTH));
  assign w_div_op = (op == OP_DIVU) || (op == OP_DIV);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_mode    (r_div),
    .i_acc     (r_acc),
    .i_operand (r_opnd),
    .i_bit     (r_div ? r_q[WIDTH-1] : r_q[0]),
    .o_acc     (w_step_acc),
    .o_bit     (w_step_bit)
  );

`ifdef MULDIV_SIGNED_EN
  logic                 w_sgn;
  logic                 w_rs_neg;
  logic                 w_rt_neg;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_fix;

  assign w_sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign w_rs_neg = w_sgn & rs_data[WIDTH-1];
  assign w_rt_neg = w_sgn & rt_data[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rs_data : rs_data;
  assign w_rt_mag = w_rt_neg ? -rt_data : rt_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_neg_q <= w_rs_neg ^ w_rt_neg;
      r_neg_r <= w_rs_neg;
    end
  end

  // Product and quotient share the xor sign; remainder follows the dividend.
  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_res_hi   = r_div ? (r_neg_r ? -r_acc : r_acc) : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_res_lo   = r_div ? (r_neg_q ? -r_q : r_q) : w_prod_fix[WIDTH-1:0];
`else
  assign w_rs_mag = rs_data;
  assign w_rt_mag = rt_data;
  assign w_res_hi = r_acc;
  assign w_res_lo = r_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // mul: {acc,q} = {0, multiplier} shifts right; div: {acc,q} = {0, dividend} shifts left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_opnd <= '0;
      r_div  <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_div  <= w_div_op;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_q    <= w_div_op ? w_rs_mag : w_rt_mag;
            r_opnd <= w_div_op ? w_rt_mag : w_rs_mag;
          end else begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_step_acc;
            r_q   <= r_div ? {r_q[WIDTH-2:0], w_step_bit} : {w_step_bit, r_q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: arithmetic reference model, directed corner cases, random ops.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          cyc = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit          sg;
    logic [31:0] q;
    logic [31:0] r;
    longint      sa;
    longint      sbv;
`ifdef MULDIV_SIGNED_EN
    sg = o[1];
`else
    sg = 1'b0;
`endif
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (!o[0]) begin
      if (sg) return 64'(sa * sbv);
      return {32'b0, a} * {32'b0, b};
    end
    if (b == 32'd0) begin
      q = (sg && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      return {a, q};
    end
    if (sg) begin
      q = 32'(sa / sbv);
      r = 32'(sa % sbv);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding op, at the right cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("result_hi", hi, e.hi);
        chk("result_lo", lo, e.lo);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Leaves the caller at the negedge after E0.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit we_hi, input logic [31:0] wd);
    logic [63:0] r;
    exp_t        e;
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1; hi_we = we_hi; wdata = wd;
    r = model(o, a, b);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.cyc = cyc + 34;
    exp_q.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    rs_data = $urandom; rt_data = $urandom;
  endtask

  // Bounded wait: after 34 more negedges the op must be retired and the unit idle.
  task automatic finish_op(input string name);
    repeat (34) @(negedge clk);
    #1;
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
    issue(o, a, b, 1'b0, 32'd0);
    finish_op(name);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] p_hi;
    int          d0;

    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Max unsigned product, with cycle-exact busy/done profile.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
    chk("busy_e0", 32'(busy), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk("busy_run", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("busy_e33", 32'(busy), 32'd0);
    chk("done_e33", 32'(done), 32'd1);
    @(negedge clk);
    chk("done_e34", 32'(done), 32'd0);
    chk("mult_max_hi", hi, 32'hFFFF_FFFE);
    chk("mult_max_lo", lo, 32'h0000_0001);
    exp_q.delete();

    run(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    chk("divu_100_7_lo", lo, 32'd14);
    chk("divu_100_7_hi", hi, 32'd2);
    run(OP_DIVU, 32'd5, 32'd0, "divu_by0");
    chk("divu_by0_hi", hi, 32'd5);
    chk("divu_by0_lo", lo, 32'hFFFF_FFFF);

    run(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_m3_5");
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run(OP_DIV, 32'hFFFF_FFF0, 32'd0, "div_neg_by0");

    // Start and MTHI while busy are ignored; start in DONE is ignored.
    p_hi = m_hi;
    d0 = n_done;
    issue(OP_MULTU, 32'd12345, 32'd6789, 1'b0, 32'd0);
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_DIVU; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_in_run", hi, p_hi);
    repeat (27) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    chk("one_done_pulse", 32'(n_done - d0), 32'd1);
    chk("first_result_lo", lo, m_lo);
    exp_q.delete();

    // Reset mid-operation.
    issue(OP_MULTU, $urandom, $urandom, 1'b0, 32'd0);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    run(OP_MULTU, 32'd6, 32'd7, "mult_6_7");
    chk("mult_6_7_lo", lo, 32'd42);
    chk("mult_6_7_hi", hi, 32'd0);

    // start beats a same-cycle MTHI in IDLE.
    p_hi = m_hi;
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'hDEAD);
    chk("mthi_dropped", hi, p_hi);
    finish_op("divu_with_mthi");
    chk("after_mthi_hi", hi, 32'd2);

    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo_hi", hi, 32'h1234);
    chk("mthilo_lo", lo, 32'h1234);
    hi_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_only_hi", hi, 32'hABCD);
    chk("mthi_only_lo", lo, 32'h1234);

    for (int i = 0; i < 40; i++) begin
      run(2'($urandom_range(0, 3)), pick(), pick(), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
